fsm_step_controller: RTL and testbench

- Sequences the lab state machine by generating its clock-enable ("step") and its registered transition input from board controls.
- Replaces driving the FSM clock directly from a push-button. The FSM then runs on the system clock and advances one state per `step` pulse.
- Step sources: a debounced manual key, or a free-running auto-step timer. A step counter is provided for display alongside the FSM state.

---
 rtl/fsm_step_controller_pkg.sv | 23 ++
 rtl/fsm_step_controller_if.sv | 32 +++
 rtl/fsm_step_controller_sync2.sv | 24 ++
 rtl/fsm_step_controller.sv | 161 ++++++++++++++++
 tb/tb_fsm_step_controller.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_step_controller_pkg.sv
// Shared types and build defaults for the FSM step controller.
// Holds the debounce state enum and sim/board timing constants.
package fsm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CNT,
    PRESSED,
    RELEASE_CNT
  } db_state_t;

  localparam int SIM_DEBOUNCE_CYCLES   = 16;
  localparam int BOARD_DEBOUNCE_CYCLES = 500000;
  localparam int SIM_AUTO_PERIOD       = 8;
  localparam int BOARD_AUTO_PERIOD     = 25000000;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fsm_step_controller_if.sv
// Board-control and step bundle between the controller and its user.
// master drives raw controls; slave (controller) drives step outputs.
interface fsm_step_controller_if #(
  parameter int CNT_W = 8
);

  logic             key_n;
  logic             auto_mode;
  logic             sw_transition;
  logic             step;
  logic             transition;
  logic [CNT_W-1:0] step_count;

  modport master (
    output key_n,
    output auto_mode,
    output sw_transition,
    input  step,
    input  transition,
    input  step_count
  );

  modport slave (
    input  key_n,
    input  auto_mode,
    input  sw_transition,
    output step,
    output transition,
    output step_count
  );

endinterface

// File: rtl/fsm_step_controller_sync2.sv
// Two-flop synchronizer with a parameterized reset value.
// Ports: clock, reset (async active-low), d (raw), q (synchronized).
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/fsm_step_controller.sv
// Step/transition generator for the lab FSM (debounced key or timer).
// Ports: clock, reset (async active-low), bus (controls in, step out).
module fsm_step_controller
  import fsm_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES,
  parameter int AUTO_PERIOD     = SIM_AUTO_PERIOD,
  parameter int CNT_W           = 8
) (
  input logic                 clock,
  input logic                 reset,
  fsm_step_controller_if.slave bus
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int PW = cnt_width(AUTO_PERIOD);

  localparam logic [DW-1:0] DMAX =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PMAX =
    PW'(AUTO_PERIOD - 1);

  logic key_s;
  logic auto_s;
  logic sw_s;

  sync2 #(.RST_VAL(1'b1)) u_key (
    .clock (clock),
    .reset (reset),
    .d     (bus.key_n),
    .q     (key_s)
  );

  sync2 #(.RST_VAL(1'b0)) u_auto (
    .clock (clock),
    .reset (reset),
    .d     (bus.auto_mode),
    .q     (auto_s)
  );

  sync2 #(.RST_VAL(1'b0)) u_sw (
    .clock (clock),
    .reset (reset),
    .d     (bus.sw_transition),
    .q     (sw_s)
  );

  db_state_t       state;
  db_state_t       state_nxt;
  logic [DW-1:0]   dcnt;
  logic [DW-1:0]   dcnt_nxt;
  logic            press_evt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    press_evt = 1'b0;
    unique case (state)
      IDLE: begin
        if (!key_s) begin
          state_nxt = PRESS_CNT;
          dcnt_nxt  = '0;
        end
      end
      PRESS_CNT: begin
        if (key_s) begin
          state_nxt = IDLE;
        end else if (dcnt == DMAX) begin
          state_nxt = PRESSED;
          press_evt = 1'b1;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_nxt = RELEASE_CNT;
          dcnt_nxt  = '0;
        end
      end
      RELEASE_CNT: begin
        // a glitch back low resumes the held press silently
        if (!key_s) begin
          state_nxt = PRESSED;
        end else if (dcnt == DMAX) begin
          state_nxt = IDLE;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        dcnt_nxt  = '0;
      end
    endcase
  end

  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic          wrap;
  logic          auto_evt;

  // held at 0 while manual, so a rising auto_s restarts the period
  assign wrap     = (presc == PMAX);
  assign auto_evt = auto_s & wrap;

  always_comb begin
    presc_nxt = '0;
    if (auto_s && !wrap) begin
      presc_nxt = presc + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else begin
      presc <= presc_nxt;
    end
  end

  logic             step_q;
  logic             trans_q;
  logic [CNT_W-1:0] count_q;
  logic             step_req;
  logic             step_nxt;

  // a mode switch could line up two events back to back;
  // the ~step_q term keeps step a single-cycle pulse
  assign step_req = auto_s ? auto_evt : press_evt;
  assign step_nxt = step_req & ~step_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step_q  <= 1'b0;
      trans_q <= 1'b0;
      count_q <= '0;
    end else begin
      step_q <= step_nxt;
      if (step_nxt) begin
        trans_q <= sw_s;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.step       = step_q;
  assign bus.transition = trans_q;
  assign bus.step_count = count_q;

endmodule

// File: tb/tb_fsm_step_controller.sv
// Self-checking bench for fsm_step_controller.
// Directed vector table, corner sequences and a random run vs. a model.
module tb_fsm_step_controller;
  import fsm_ctrl_pkg::*;

  localparam int D = 16;
  localparam int P = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic key_n = 1'b1;
  logic auto_mode = 1'b0;
  logic sw_transition = 1'b0;

  fsm_step_controller_if #(.CNT_W(8)) bus8 ();
  fsm_step_controller_if #(.CNT_W(2)) bus2 ();

  assign bus8.key_n         = key_n;
  assign bus8.auto_mode     = auto_mode;
  assign bus8.sw_transition = sw_transition;
  assign bus2.key_n         = key_n;
  assign bus2.auto_mode     = auto_mode;
  assign bus2.sw_transition = sw_transition;

  fsm_step_controller #(
    .DEBOUNCE_CYCLES (D),
    .AUTO_PERIOD     (P),
    .CNT_W           (8)
  ) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
  );

  fsm_step_controller #(
    .DEBOUNCE_CYCLES (D),
    .AUTO_PERIOD     (P),
    .CNT_W           (2)
  ) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: synchronizers as delay lines, debounce as a
  // run length of samples disagreeing with the accepted level,
  // auto steps every P-th cycle of a continuous auto_s run.
  bit m_k1, m_k2, m_a1, m_a2, m_s1, m_s2;
  bit acc;
  int run;
  int arun;
  bit m_step;
  bit m_trans;
  int m_count;

  function automatic void model_reset();
    m_k1 = 1; m_k2 = 1;
    m_a1 = 0; m_a2 = 0;
    m_s1 = 0; m_s2 = 0;
    acc = 1; run = 0; arun = 0;
    m_step = 0; m_trans = 0; m_count = 0;
  endfunction

  function automatic void model_edge();
    bit press;
    bit areq;
    bit req;
    bit nstep;
    press = 0;
    areq = 0;
    if (m_k2 != acc) begin
      run++;
      if (run == D + 1) begin
        acc = m_k2;
        run = 0;
        press = !m_k2;
      end
    end else begin
      run = 0;
    end
    if (m_a2) begin
      areq = ((arun + 1) % P) == 0;
      arun++;
    end else begin
      arun = 0;
    end
    req = m_a2 ? areq : press;
    nstep = req && !m_step;
    m_step = nstep;
    if (nstep) begin
      m_trans = m_s2;
      m_count++;
    end
    m_k2 = m_k1; m_k1 = key_n;
    m_a2 = m_a1; m_a1 = auto_mode;
    m_s2 = m_s1; m_s1 = sw_transition;
  endfunction

  task automatic tick();
    @(posedge clock);
    if (!reset) model_reset();
    else model_edge();
    #1;
    check("step", bus8.step, m_step);
    check("transition", bus8.transition, m_trans);
    check("count8", bus8.step_count, m_count % 256);
    check("count2", bus2.step_count, m_count % 4);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    key_n = 1'b1;
    auto_mode = 1'b0;
    sw_transition = 1'b0;
    #1;
    check("rst_step", bus8.step, 0);
    check("rst_trans", bus8.transition, 0);
    check("rst_count", bus8.step_count, 0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  typedef struct {
    int kind;
    int len;
    bit sw;
    int exp_first;
    int exp_steps;
    bit exp_trans;
    int exp_cnt2;
  } vec_t;

  vec_t vecs[4];

  int first;
  int steps;

  initial begin
    vecs[0] = '{0, 80, 1'b1, D + 3, 1, 1'b1, 1};
    vecs[1] = '{1, 100, 1'b1, 0, 0, 1'b0, 0};
    vecs[2] = '{2, 80, 1'b1, P + 2, 6, 1'b1, 2};
    vecs[3] = '{3, 60, 1'b0, P + 2, 5, 1'b0, 1};

    for (int v = 0; v < 4; v++) begin
      do_reset();
      sw_transition = vecs[v].sw;
      first = 0;
      steps = 0;
      for (int c = 1; c <= vecs[v].len; c++) begin
        case (vecs[v].kind)
          0: key_n = (c <= 40) ? 1'b0 : 1'b1;
          1: key_n = (c <= 60) ? 1'(((c - 1) / 5) % 2) : 1'b1;
          2: begin
            auto_mode = (c <= 50);
            key_n = !(c >= 5 && c <= 45);
          end
          default: auto_mode = (c <= 42);
        endcase
        tick();
        if (bus8.step === 1'b1) begin
          steps++;
          if (first == 0) first = c;
        end
      end
      check($sformatf("v%0d_first", v), first, vecs[v].exp_first);
      check($sformatf("v%0d_steps", v), steps, vecs[v].exp_steps);
      check($sformatf("v%0d_count", v), bus8.step_count,
            vecs[v].exp_steps);
      check($sformatf("v%0d_trans", v), bus8.transition,
            vecs[v].exp_trans);
      check($sformatf("v%0d_cnt2", v), bus2.step_count,
            vecs[v].exp_cnt2);
    end

    // transition held between steps, updated at the next step
    do_reset();
    sw_transition = 1'b1;
    auto_mode = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      if (c == 11) sw_transition = 1'b0;
      tick();
      if (c == 10) check("tc_step10", bus8.step, 1);
      if (c == 10) check("tc_trans10", bus8.transition, 1);
      if (c == 17) check("tc_trans17", bus8.transition, 1);
      if (c == 18) check("tc_trans18", bus8.transition, 0);
    end
    auto_mode = 1'b0;
    for (int c = 0; c < 10; c++) tick();

    // reset in the middle of a press, key kept held
    key_n = 1'b0;
    for (int c = 1; c <= 13; c++) tick();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_step", bus8.step, 0);
    check("mid_trans", bus8.transition, 0);
    check("mid_count", bus8.step_count, 0);
    tick();
    tick();
    reset = 1'b1;
    first = 0;
    steps = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bus8.step === 1'b1) begin
        steps++;
        if (first == 0) first = c;
      end
    end
    check("mid_first", first, D + 3);
    check("mid_steps", steps, 1);
    key_n = 1'b1;

    // random run against the model
    begin
      int key_hold;
      int auto_hold;
      do_reset();
      key_hold = 10;
      auto_hold = 200;
      for (int c = 0; c < 4000; c++) begin
        if (key_hold == 0) begin
          key_n = ~key_n;
          key_hold = $urandom_range(1, 40);
        end else begin
          key_hold--;
        end
        if (auto_hold == 0) begin
          auto_mode = ~auto_mode;
          auto_hold = $urandom_range(20, 120);
        end else begin
          auto_hold--;
        end
        if ($urandom_range(0, 9) == 0)
          sw_transition = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1499) == 0) begin
          reset = 1'b0;
          model_reset();
          tick();
          tick();
          reset = 1'b1;
        end
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
